// File: rtl/swg_pkg.sv
// rtl/swg_pkg.sv - shared types and constants for the DDS sine generator and frequency meter
package swg_pkg;

  typedef enum logic [1:0] {
    SEEK   = 2'd0,
    COUNT  = 2'd1,
    DIVIDE = 2'd2
  } meter_state_t;

  localparam int SWG_PHASE_WIDTH = 10;
  localparam int DIV_EXTRA_ITERS = 2;
  localparam int DIV_ITERS       = SWG_PHASE_WIDTH + DIV_EXTRA_ITERS;

  function automatic int mid_level(input int data_width);
    return 1 << (data_width - 1);
  endfunction

  function automatic int div_iters(input int phase_width);
    return phase_width + DIV_EXTRA_ITERS;
  endfunction

endpackage

// File: rtl/sine_freq_meter_recip_divider.sv
// rtl/sine_freq_meter_recip_divider.sv - restoring divider giving round(2^PHASE_WIDTH / divisor), saturated
// o_done and o_quotient are combinational during the final iteration so the caller can register them.
module recip_divider
  import swg_pkg::*;
#(
  parameter int PHASE_WIDTH  = 10,
  parameter int PERIOD_WIDTH = PHASE_WIDTH + 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_start,
  input  logic [PERIOD_WIDTH-1:0] i_divisor,
  output logic                    o_busy,
  output logic                    o_done,
  output logic [PHASE_WIDTH-1:0]  o_quotient
);

  localparam int ITERS = div_iters(PHASE_WIDTH);
  localparam int QW    = ITERS;
  localparam int RW    = PERIOD_WIDTH + 1;
  localparam int CW    = $clog2(ITERS + 1);

  // r_shift shifts dividend bits out of the top while quotient bits enter at the bottom
  logic [QW-1:0]           r_shift;
  logic [PERIOD_WIDTH-1:0] r_rem;
  logic [PERIOD_WIDTH-1:0] r_divisor;
  logic [CW-1:0]           r_iter;
  logic                    r_busy;

  logic [RW-1:0]           w_trial;
  logic                    w_ge;
  logic [PERIOD_WIDTH-1:0] w_rem_next;
  logic [QW-1:0]           w_shift_next;

  always_comb begin
    w_trial      = {r_rem, r_shift[QW-1]};
    w_ge         = (w_trial >= {1'b0, r_divisor});
    w_rem_next   = w_ge ? (w_trial[PERIOD_WIDTH-1:0] - r_divisor) : w_trial[PERIOD_WIDTH-1:0];
    w_shift_next = {r_shift[QW-2:0], w_ge};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy    <= 1'b0;
      r_iter    <= '0;
      r_rem     <= '0;
      r_shift   <= '0;
      r_divisor <= '0;
    end else if (i_start && !r_busy) begin
      r_busy    <= 1'b1;
      r_iter    <= CW'(ITERS);
      r_rem     <= '0;
      r_shift   <= {2'b01, {PHASE_WIDTH{1'b0}}} + QW'(i_divisor[PERIOD_WIDTH-1:1]);
      r_divisor <= i_divisor;
    end else if (r_busy) begin
      r_rem   <= w_rem_next;
      r_shift <= w_shift_next;
      r_iter  <= r_iter - CW'(1);
      if (r_iter == CW'(1)) r_busy <= 1'b0;
    end
  end

  assign o_busy     = r_busy;
  assign o_done     = r_busy && (r_iter == CW'(1));
  assign o_quotient = (|w_shift_next[QW-1:PHASE_WIDTH]) ? '1 : w_shift_next[PHASE_WIDTH-1:0];

endmodule

// File: rtl/sine_freq_meter.sv
// rtl/sine_freq_meter.sv - hysteretic rising-crossing detector, period counter and reciprocal frequency estimate
module sine_freq_meter
  import swg_pkg::*;
#(
  parameter int PHASE_WIDTH  = 10,
  parameter int DATA_WIDTH   = 8,
  parameter int PERIOD_WIDTH = PHASE_WIDTH + 2,
  parameter int HYST         = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [DATA_WIDTH-1:0]   sample_in,
  input  logic                    sample_valid,
  output logic [PERIOD_WIDTH-1:0] period_out,
  output logic [PHASE_WIDTH-1:0]  freq_est,
  output logic                    meas_valid,
  output logic                    locked,
  output logic                    overrun,
  output logic                    timeout
);

  localparam int MID = mid_level(DATA_WIDTH);
  localparam logic [DATA_WIDTH-1:0]   LO_TH    = DATA_WIDTH'(MID - HYST);
  localparam logic [DATA_WIDTH-1:0]   HI_TH    = DATA_WIDTH'(MID + HYST);
  localparam logic [PERIOD_WIDTH-1:0] CNT_NEAR = {{(PERIOD_WIDTH-1){1'b1}}, 1'b0};

  meter_state_t            r_state;
  logic [DATA_WIDTH-1:0]   r_sample;
  logic                    r_sample_v;
  logic                    r_armed;
  logic [PERIOD_WIDTH-1:0] r_count;
  logic [PERIOD_WIDTH-1:0] r_cap_period;
  logic [PERIOD_WIDTH-1:0] r_period;
  logic [PHASE_WIDTH-1:0]  r_freq;
  logic                    r_locked;
  logic                    r_have_prev;
  logic                    r_meas_valid;
  logic                    r_overrun;
  logic                    r_timeout;

  logic                    w_low;
  logic                    w_high;
  logic                    w_at_max;
  logic                    w_timeout;
  logic                    w_edge;
  logic [PERIOD_WIDTH-1:0] w_count_inc;
  logic                    w_div_start;
  logic                    w_div_busy;
  logic                    w_div_done;
  logic [PHASE_WIDTH-1:0]  w_quot;

  // Timeout outranks an edge on the same sample; the counter only saturates while dividing.
  always_comb begin
    w_low       = r_sample_v && (r_sample <= LO_TH);
    w_high      = r_sample_v && (r_sample >= HI_TH);
    w_at_max    = (r_count >= CNT_NEAR);
    w_timeout   = r_sample_v && w_at_max && (r_state != DIVIDE);
    w_edge      = w_high && r_armed && !w_timeout;
    w_count_inc = w_at_max ? '1 : r_count + PERIOD_WIDTH'(1);
    w_div_start = w_edge && (r_state == COUNT) && !w_div_busy;
  end

  recip_divider #(
    .PHASE_WIDTH  (PHASE_WIDTH),
    .PERIOD_WIDTH (PERIOD_WIDTH)
  ) u_div (
    .clk        (clk),
    .reset      (reset),
    .i_start    (w_div_start),
    .i_divisor  (w_count_inc),
    .o_busy     (w_div_busy),
    .o_done     (w_div_done),
    .o_quotient (w_quot)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= SEEK;
      r_sample     <= '0;
      r_sample_v   <= 1'b0;
      r_armed      <= 1'b0;
      r_count      <= '0;
      r_cap_period <= '0;
      r_period     <= '0;
      r_freq       <= '0;
      r_locked     <= 1'b0;
      r_have_prev  <= 1'b0;
      r_meas_valid <= 1'b0;
      r_overrun    <= 1'b0;
      r_timeout    <= 1'b0;
    end else begin
      r_sample     <= sample_in;
      r_sample_v   <= sample_valid;
      r_meas_valid <= 1'b0;
      r_overrun    <= w_edge && (r_state == DIVIDE);
      r_timeout    <= w_timeout;
      if (w_timeout) begin
        r_state     <= SEEK;
        r_armed     <= 1'b0;
        r_count     <= '0;
        r_period    <= '0;
        r_freq      <= '0;
        r_locked    <= 1'b0;
        r_have_prev <= 1'b0;
      end else begin
        if (r_sample_v) begin
          if (w_low) r_armed <= 1'b1;
          else if (w_edge) r_armed <= 1'b0;
          r_count <= w_edge ? '0 : w_count_inc;
        end
        case (r_state)
          SEEK: if (w_edge) r_state <= COUNT;
          COUNT: begin
            if (w_div_start) begin
              r_state      <= DIVIDE;
              r_cap_period <= w_count_inc;
            end
          end
          DIVIDE: begin
            if (w_div_done) begin
              r_state      <= COUNT;
              r_meas_valid <= 1'b1;
              r_period     <= r_cap_period;
              r_freq       <= w_quot;
              r_locked     <= r_have_prev && (w_quot == r_freq);
              r_have_prev  <= 1'b1;
            end
          end
          default: r_state <= SEEK;
        endcase
      end
    end
  end

  assign period_out = r_period;
  assign freq_est   = r_freq;
  assign meas_valid = r_meas_valid;
  assign locked     = r_locked;
  assign overrun    = r_overrun;
  assign timeout    = r_timeout;

endmodule

// File: tb/tb_sine_freq_meter.sv
// tb/tb_sine_freq_meter.sv - scoreboard and vector-table bench for sine_freq_meter
module tb_sine_freq_meter;

  localparam int PW      = 10;
  localparam int DW      = 8;
  localparam int PERW    = 12;
  localparam int HYST    = 4;
  localparam int MID     = 128;
  localparam int ITERS   = PW + 2;
  localparam int CNT_MAX = (1 << PERW) - 1;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [DW-1:0]   sample_in = '0;
  logic            sample_valid = 1'b0;
  logic [PERW-1:0] period_out;
  logic [PW-1:0]   freq_est;
  logic            meas_valid, locked, overrun, timeout;

  always #5 clk = ~clk;

  sine_freq_meter #(.PHASE_WIDTH(PW), .DATA_WIDTH(DW), .PERIOD_WIDTH(PERW), .HYST(HYST)) dut (
    .clk(clk), .reset(reset), .sample_in(sample_in), .sample_valid(sample_valid),
    .period_out(period_out), .freq_est(freq_est), .meas_valid(meas_valid),
    .locked(locked), .overrun(overrun), .timeout(timeout)
  );

  typedef struct { int due; int period; int freq; bit lck; } meas_t;
  typedef struct { int lo_len; int hi_len; int amp; int n_periods; bit do_reset;
                   bit exp_meas; bit exp_ovr; int exp_period; int exp_freq; } vec_t;

  meas_t q_meas[$];
  int    q_ovr[$];
  int    q_to[$];
  int    cyc = 0;
  int    checks = 0;
  int    errors = 0;
  int    n_meas = 0, n_ovr = 0, n_to = 0, n_caps = 0;

  bit m_armed, m_seek, m_cap_valid, m_have_prev;
  int m_count, m_cap_idx, m_prev_freq;

  function automatic int exp_freq(input int p);
    int q;
    q = ((1 << PW) + p / 2) / p;
    return (q > (1 << PW) - 1) ? (1 << PW) - 1 : q;
  endfunction

  function automatic logic [DW-1:0] dds_sample(input int phase);
    real a;
    a = 128.0 + 127.0 * $sin(6.283185307179586 * phase / 1024.0);
    return DW'(int'(a));
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    q_meas.delete(); q_ovr.delete(); q_to.delete();
    m_armed = 0; m_seek = 1; m_cap_valid = 0; m_have_prev = 0;
    m_count = 0; m_cap_idx = 0; m_prev_freq = 0;
  endtask

  task automatic model_sample(input logic [DW-1:0] s, input bit v);
    int inc, f;
    bit in_div, lo, hi, edg;
    meas_t e;
    if (v) begin
      inc = m_count + 1;
      in_div = m_cap_valid && (cyc - m_cap_idx >= 1) && (cyc - m_cap_idx <= ITERS);
      if (inc >= CNT_MAX && !in_div) begin
        q_to.push_back(cyc + 2);
        m_count = 0; m_seek = 1; m_armed = 0; m_have_prev = 0;
      end else begin
        if (inc > CNT_MAX) inc = CNT_MAX;
        lo = (s <= MID - HYST);
        hi = (s >= MID + HYST);
        edg = hi && m_armed;
        if (lo) m_armed = 1; else if (edg) m_armed = 0;
        if (edg) begin
          m_count = 0;
          if (m_seek) m_seek = 0;
          else if (in_div) q_ovr.push_back(cyc + 2);
          else begin
            f = exp_freq(inc);
            e.due = cyc + ITERS + 2; e.period = inc; e.freq = f;
            e.lck = m_have_prev && (f == m_prev_freq);
            q_meas.push_back(e);
            m_prev_freq = f; m_have_prev = 1; m_cap_idx = cyc; m_cap_valid = 1; n_caps++;
          end
        end else m_count = inc;
      end
    end
  endtask

  task automatic monitor_now();
    bit exp;
    exp = (q_meas.size() > 0) && (q_meas[0].due == cyc);
    if (exp || meas_valid) begin
      chk("meas_valid", int'(meas_valid), int'(exp));
      if (exp) begin
        chk("period_out", int'(period_out), q_meas[0].period);
        chk("freq_est", int'(freq_est), q_meas[0].freq);
        chk("locked", int'(locked), int'(q_meas[0].lck));
        void'(q_meas.pop_front());
      end
    end
    if (meas_valid) n_meas++;
    exp = (q_ovr.size() > 0) && (q_ovr[0] == cyc);
    if (exp || overrun) begin
      chk("overrun", int'(overrun), int'(exp));
      if (exp) void'(q_ovr.pop_front());
    end
    if (overrun) n_ovr++;
    exp = (q_to.size() > 0) && (q_to[0] == cyc);
    if (exp || timeout) begin
      chk("timeout", int'(timeout), int'(exp));
      if (exp) begin
        chk("timeout_period_clr", int'(period_out), 0);
        chk("timeout_freq_clr", int'(freq_est), 0);
        chk("timeout_locked_clr", int'(locked), 0);
        void'(q_to.pop_front());
      end
    end
    if (timeout) n_to++;
  endtask

  task automatic step(input logic [DW-1:0] s, input bit v, input bit r);
    @(negedge clk);
    monitor_now();
    sample_in = s; sample_valid = v; reset = r;
    if (r) model_reset(); else model_sample(s, v);
    cyc++;
  endtask

  task automatic reset_dut();
    repeat (3) step(DW'(MID), 1'b0, 1'b1);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_period"}, int'(period_out), 0);
    chk({tag, "_freq"}, int'(freq_est), 0);
    chk({tag, "_mv"}, int'(meas_valid), 0);
    chk({tag, "_locked"}, int'(locked), 0);
    chk({tag, "_ovr"}, int'(overrun), 0);
    chk({tag, "_to"}, int'(timeout), 0);
  endtask

  task automatic run_dds(input int fcw, input int n, input bit alt);
    int phase;
    bit v;
    phase = 0;
    for (int k = 0; k < n; k++) begin
      v = alt ? (k % 2 == 0) : 1'b1;
      if (v) begin
        step(dds_sample(phase), 1'b1, 1'b0);
        phase = (phase + fcw) % 1024;
      end else step(DW'($urandom_range(0, 255)), 1'b0, 1'b0);
    end
  endtask

  task automatic square_step(input int k, input int lo_len, input int hi_len, input int amp);
    if (k % (lo_len + hi_len) < lo_len) step(DW'(MID - amp), 1'b1, 1'b0);
    else step(DW'(MID + amp), 1'b1, 1'b0);
  endtask

  vec_t vecs[7];
  int   meas0, ovr0, to0, caps0, k;

  initial begin
    vecs[0] = '{32, 32, 3, 6, 1'b1, 1'b0, 1'b0, 0, 0};
    vecs[1] = '{32, 32, 40, 6, 1'b0, 1'b1, 1'b0, 64, 16};
    vecs[2] = '{4, 4, 40, 8, 1'b1, 1'b1, 1'b1, 8, 128};
    vecs[3] = '{1, 1, 40, 12, 1'b1, 1'b1, 1'b1, 2, 512};
    vecs[4] = '{2, 1, 40, 10, 1'b1, 1'b1, 1'b1, 3, 341};
    vecs[5] = '{1000, 1000, 40, 3, 1'b1, 1'b1, 1'b0, 2000, 1};
    vecs[6] = '{1050, 1050, 40, 3, 1'b1, 1'b1, 1'b0, 2100, 0};

    model_reset();
    reset_dut();
    step(DW'(MID), 1'b0, 1'b0);
    check_all_zero("reset");

    meas0 = n_meas;
    run_dds(10, 1200, 1'b0);
    chk("dds10_meas_seen", int'(n_meas - meas0 >= 5), 1);
    chk("dds10_freq", int'(freq_est), 10);
    chk("dds10_period_102_103", int'(period_out == 102 || period_out == 103), 1);
    chk("dds10_locked", int'(locked), 1);

    reset_dut();
    meas0 = n_meas;
    run_dds(10, 2400, 1'b1);
    chk("dds10_alt_meas_seen", int'(n_meas - meas0 >= 5), 1);
    chk("dds10_alt_freq", int'(freq_est), 10);
    chk("dds10_alt_period", int'(period_out == 102 || period_out == 103), 1);

    reset_dut();
    meas0 = n_meas; to0 = n_to;
    run_dds(0, 3 * CNT_MAX + 4, 1'b0);
    chk("const_timeouts", n_to - to0, 3);
    chk("const_no_meas", n_meas - meas0, 0);
    check_all_zero("const");

    for (int v = 0; v < 7; v++) begin
      if (vecs[v].do_reset) reset_dut();
      meas0 = n_meas; ovr0 = n_ovr;
      for (int p = 0; p < vecs[v].n_periods * (vecs[v].lo_len + vecs[v].hi_len); p++)
        square_step(p, vecs[v].lo_len, vecs[v].hi_len, vecs[v].amp);
      repeat (20) step(DW'(MID - vecs[v].amp), 1'b1, 1'b0);
      chk($sformatf("vec%0d_meas", v), int'(n_meas > meas0), int'(vecs[v].exp_meas));
      chk($sformatf("vec%0d_ovr", v), int'(n_ovr > ovr0), int'(vecs[v].exp_ovr));
      chk($sformatf("vec%0d_period", v), int'(period_out), vecs[v].exp_period);
      chk($sformatf("vec%0d_freq", v), int'(freq_est), vecs[v].exp_freq);
    end

    reset_dut();
    caps0 = n_caps; k = 0;
    while (n_caps < caps0 + 2 && k < 2000) begin
      square_step(k, 32, 32, 40);
      k++;
    end
    chk("rst_two_captures", int'(n_caps >= caps0 + 2), 1);
    chk("rst_prior_freq", int'(freq_est), 16);
    for (int j = 0; j < 5; j++) begin
      square_step(k, 32, 32, 40);
      k++;
    end
    step(DW'(MID), 1'b1, 1'b1);
    step(DW'(MID - 40), 1'b1, 1'b0);
    check_all_zero("rst_div");
    meas0 = n_meas;
    for (int j = 1; j < 90; j++) square_step(j, 32, 32, 40);
    chk("rst_first_edge_no_capture", n_meas - meas0, 0);
    for (int j = 90; j < 200; j++) square_step(j, 32, 32, 40);
    chk("rst_recovers", int'(n_meas > meas0), 1);

    repeat (20) step(DW'(MID), 1'b0, 1'b0);
    chk("sb_drained", q_meas.size() + q_ovr.size() + q_to.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
